fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding word request at a time,
// and pushes {pc, instr} into the fetch->decode pipe. Optional stall counter: FETCH_PERF_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in,
  output logic        ic_req_out,
  output logic [31:0] ic_addr_out,
  input  logic        ic_ack_in,
  input  logic [31:0] ic_ack_data_in,
  input  logic        fet_full_in,
  output logic        fet_wr_out,
  output logic [63:0] fet_data_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fet_stall_cnt_out
`endif
);

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_PUSH = 2'd1,
    F_DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [63:0]  hold_q;
  logic [31:0]  redir_q;

  logic [31:0]  flush_tgt;
  logic         mem_ack;

  assign flush_tgt = flush_pc_in & ~32'h3;

  // Outputs are gated by reset so the memory and pipe see nothing while reset is held.
  assign fet_wr_out   = !reset_in && (state == F_PUSH) && !fet_full_in && !flush_in;
  assign ic_req_out   = !reset_in && ((state == F_REQ) || (state == F_DROP) || fet_wr_out);
  assign ic_addr_out  = pc_q;
  assign fet_data_out = hold_q;
  assign mem_ack      = ic_ack_in && ic_req_out;

  // In F_DROP pc_q still holds the stale request address; the redirect waits in redir_q.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state   <= F_REQ;
      pc_q    <= RESET_PC_ALIGNED;
      hold_q  <= 64'd0;
      redir_q <= 32'd0;
    end else begin
      case (state)
        F_REQ: begin
          if (flush_in) begin
            if (mem_ack) begin
              pc_q <= flush_tgt;
            end else begin
              redir_q <= flush_tgt;
              state   <= F_DROP;
            end
          end else if (mem_ack) begin
            hold_q <= {pc_q, ic_ack_data_in};
            pc_q   <= pc_q + 32'd4;
            state  <= F_PUSH;
          end
        end
        F_PUSH: begin
          if (flush_in) begin
            pc_q  <= flush_tgt;
            state <= F_REQ;
          end else if (!fet_full_in) begin
            if (mem_ack) begin
              hold_q <= {pc_q, ic_ack_data_in};
              pc_q   <= pc_q + 32'd4;
            end else begin
              state <= F_REQ;
            end
          end
        end
        F_DROP: begin
          if (flush_in && mem_ack) begin
            pc_q  <= flush_tgt;
            state <= F_REQ;
          end else if (flush_in) begin
            redir_q <= flush_tgt;
          end else if (mem_ack) begin
            pc_q  <= redir_q;
            state <= F_REQ;
          end
        end
        default: state <= F_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating count of cycles the pipe held us off with an instruction ready.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      fet_stall_cnt_out <= 32'd0;
    end else if ((state == F_PUSH) && fet_full_in && (fet_stall_cnt_out != 32'hFFFF_FFFF)) begin
      fet_stall_cnt_out <= fet_stall_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with RESET_PC = 0x100 and a
// zero-latency memory model whose ack is enabled per cycle by the stimulus.
module tb_fetch_stage;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        flush_in;
  logic [31:0] flush_pc_in;
  logic        ic_req_out;
  logic [31:0] ic_addr_out;
  logic        ic_ack_in;
  logic [31:0] ic_ack_data_in;
  logic        fet_full_in;
  logic        fet_wr_out;
  logic [63:0] fet_data_out;
`ifdef FETCH_PERF_EN
  logic [31:0] fet_stall_cnt_out;
`endif

  logic ackEn;
  int   compared = 0;
  int   mismatched = 0;

  function automatic logic [31:0] instrOf(input logic [31:0] addr);
    return addr ^ 32'h5A5A_1234;
  endfunction

  assign ic_ack_in      = ackEn & ic_req_out;
  assign ic_ack_data_in = instrOf(ic_addr_out);

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .flush_in       (flush_in),
    .flush_pc_in    (flush_pc_in),
    .ic_req_out     (ic_req_out),
    .ic_addr_out    (ic_addr_out),
    .ic_ack_in      (ic_ack_in),
    .ic_ack_data_in (ic_ack_data_in),
    .fet_full_in    (fet_full_in),
    .fet_wr_out     (fet_wr_out),
    .fet_data_out   (fet_data_out)
`ifdef FETCH_PERF_EN
    ,
    .fet_stall_cnt_out (fet_stall_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the falling edge and outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic f, input logic [31:0] fpc, input logic ack, input logic full);
    @(negedge clk_in);
    flush_in    = f;
    flush_pc_in = fpc;
    ackEn       = ack;
    fet_full_in = full;
    #1;
  endtask

  task automatic checkBus(input string tag, input logic req, input logic [31:0] addr, input logic wr);
    checkOutput({tag, ".req"}, 64'(ic_req_out), 64'(req));
    if (req) checkOutput({tag, ".addr"}, 64'(ic_addr_out), 64'(addr));
    checkOutput({tag, ".wr"}, 64'(fet_wr_out), 64'(wr));
  endtask

  initial begin
    reset_in    = 1'b1;
    flush_in    = 1'b0;
    flush_pc_in = 32'd0;
    ackEn       = 1'b0;
    fet_full_in = 1'b0;
    #3;
    checkOutput("rst.req", 64'(ic_req_out), 64'd0);
    checkOutput("rst.wr", 64'(fet_wr_out), 64'd0);
    checkOutput("rst.addr", 64'(ic_addr_out), 64'h100);
    checkOutput("rst.data", fet_data_out, 64'd0);
    @(negedge clk_in);
    reset_in = 1'b0;

    // Zero-wait streaming from the reset PC
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkBus("stream0", 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] pc;
      pc = 32'h100 + 32'(4 * i);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      checkBus("stream", 1'b1, pc + 32'd4, 1'b1);
      checkOutput("stream.data", fet_data_out, {pc, instrOf(pc)});
    end

    // Pipe full for five cycles holding {0x10C, instr}
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
      checkBus("full", 1'b0, 32'd0, 1'b0);
      checkOutput("full.data", fet_data_out, {32'h10C, instrOf(32'h10C)});
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkBus("release", 1'b1, 32'h110, 1'b1);
    checkOutput("release.data", fet_data_out, {32'h10C, instrOf(32'h10C)});
`ifdef FETCH_PERF_EN
    checkOutput("stallcnt", 64'(fet_stall_cnt_out), 64'd5);
`endif

    // Redirect to 0x200, then a three-cycle memory wait
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0);
    checkBus("flushpush", 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
      checkBus("wait", 1'b1, 32'h200, 1'b0);
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkBus("waitack", 1'b1, 32'h200, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkBus("waitwr", 1'b1, 32'h204, 1'b1);
    checkOutput("waitwr.data", fet_data_out, {32'h200, instrOf(32'h200)});

    // Flush while full: {0x204, instr} must never be written
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    checkBus("fullhold", 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b1);
    checkBus("flushfull", 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkBus("tgt10", 1'b1, 32'h10, 1'b0);

    // Flush to 0x403 while 0x10 is outstanding: stale ack dropped, restart at 0x400
    applyStimulus(1'b1, 32'h403, 1'b0, 1'b0);
    checkBus("dropflush", 1'b1, 32'h10, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkBus("dropwait", 1'b1, 32'h10, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkBus("dropack", 1'b1, 32'h10, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkBus("redir", 1'b1, 32'h400, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkBus("redirwr", 1'b1, 32'h404, 1'b1);
    checkOutput("redirwr.data", fet_data_out, {32'h400, instrOf(32'h400)});
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkBus("req404", 1'b1, 32'h404, 1'b0);

    // Asynchronous reset in the middle of a wait
    #2;
    reset_in = 1'b1;
    #1;
    checkBus("asyncrst", 1'b0, 32'd0, 1'b0);
    checkOutput("asyncrst.addr", 64'(ic_addr_out), 64'h100);
    checkOutput("asyncrst.data", fet_data_out, 64'd0);
`ifdef FETCH_PERF_EN
    checkOutput("asyncrst.cnt", 64'(fet_stall_cnt_out), 64'd0);
`endif
    @(negedge clk_in);
    reset_in = 1'b0;

    // PC wrap from 0xFFFF_FFFC
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    checkBus("restart", 1'b1, 32'h100, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkBus("wraplast", 1'b1, 32'hFFFF_FFFC, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkBus("wrap", 1'b1, 32'h0, 1'b1);
    checkOutput("wrap.data", fet_data_out, {32'hFFFF_FFFC, instrOf(32'hFFFF_FFFC)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
